// File: rtl/neuron_sample_feeder.sv
// rtl/neuron_sample_feeder.sv - training-sample source feeding the neuron controller, with epoch/convergence tracking
module neuron_sample_feeder #(
    parameter int DW        = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int MAX_EPOCH = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_x1,
    input  logic [DW-1:0] wr_x2,
    input  logic          wr_t,
    input  logic [AW:0]   num_samples,
    input  logic          start,
    input  logic          ready,
    input  logic          weight_changed,
    output logic [DW-1:0] x1,
    output logic [DW-1:0] x2,
    output logic          t,
    output logic          valid,
    output logic [AW-1:0] sample_idx,
    output logic [7:0]    epoch_cnt,
    output logic          epoch_done,
    output logic          converged,
    output logic          timeout,
    output logic          busy
);

    typedef enum logic [2:0] {IDLE, FETCH, PRESENT, EPOCH_END, DONE} state_t;

    state_t            state, state_nxt;
    logic [2*DW:0]     mem [DEPTH];
    logic [AW:0]       n_lat;
    logic              changed;
    logic              idle_like;
    logic              start_ok;
    logic              last;
    logic              changed_eff;
    logic              final_epoch;

    assign idle_like   = (state == IDLE) || (state == DONE);
    assign start_ok    = idle_like && start && (num_samples != '0);
    assign last        = ({1'b0, sample_idx} == (n_lat - (AW+1)'(1)));
    // A weight update arriving in the EPOCH_END cycle still belongs to the epoch being closed.
    assign changed_eff = changed | weight_changed;
    assign final_epoch = (({1'b0, epoch_cnt} + 9'd1) == 9'(MAX_EPOCH));

    assign valid      = (state == PRESENT);
    assign busy       = (state == FETCH) || (state == PRESENT) || (state == EPOCH_END);
    assign epoch_done = (state == EPOCH_END);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start_ok) state_nxt = FETCH;
            FETCH:      state_nxt = PRESENT;
            PRESENT:    if (ready) state_nxt = last ? EPOCH_END : FETCH;
            EPOCH_END:  state_nxt = (!changed_eff || final_epoch) ? DONE : FETCH;
            default:    state_nxt = IDLE;
        endcase
    end

    // Sample storage is deliberately not reset so a reset between runs keeps the training set.
    always_ff @(posedge clk) begin
        if (wr_en && idle_like) mem[wr_addr] <= {wr_x1, wr_x2, wr_t};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x1         <= '0;
            x2         <= '0;
            t          <= 1'b0;
            sample_idx <= '0;
            epoch_cnt  <= '0;
            converged  <= 1'b0;
            timeout    <= 1'b0;
            changed    <= 1'b0;
            n_lat      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        n_lat      <= (num_samples > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_samples;
                        sample_idx <= '0;
                        epoch_cnt  <= '0;
                        changed    <= 1'b0;
                        converged  <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                FETCH: begin
                    {x1, x2, t} <= mem[sample_idx];
                    if (weight_changed) changed <= 1'b1;
                end
                PRESENT: begin
                    if (weight_changed) changed <= 1'b1;
                    if (ready && !last) sample_idx <= sample_idx + 1'b1;
                end
                EPOCH_END: begin
                    if (epoch_cnt != 8'hFF) epoch_cnt <= epoch_cnt + 8'd1;
                    sample_idx <= '0;
                    if (!changed_eff) begin
                        converged <= 1'b1;
                    end else if (final_epoch) begin
                        timeout <= 1'b1;
                        changed <= 1'b1;
                    end else begin
                        changed <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
